// File: rtl/snake_key_decoder.sv
// snake_key_decoder: turns PS/2 scancode bytes (with E0/F0 prefixes) into snake heading, pause and error pulses.
module snake_key_decoder #(
  parameter int PREFIX_TIMEOUT = 100000,
  parameter int CNT_W          = 17
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] scancode,
  input  logic       flag,
  output logic [1:0] dir,
  output logic       dir_change,
  output logic       pause,
  output logic [7:0] last_make,
  output logic       seq_error
);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_inc, cnt_nxt;
  logic is_e0, is_f0, is_pfx, timeout, err;
  logic make, ext, req_ok, space_make, space_rel, dir_ok, held;
  logic [1:0] req;
  assign is_e0   = scancode == 8'hE0;
  assign is_f0   = scancode == 8'hF0;
  assign is_pfx  = is_e0 | is_f0;
  assign cnt_inc = cnt + CNT_W'(1);
  // a byte arriving in the expiry cycle wins over the timeout
  assign timeout = state != IDLE && !flag && cnt_inc == CNT_W'(PREFIX_TIMEOUT);
  assign cnt_nxt = (flag || state == IDLE || timeout) ? '0 : cnt_inc;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      cnt        <= '0;
      dir        <= 2'b11;
      dir_change <= 1'b0;
      pause      <= 1'b0;
      held       <= 1'b0;
      last_make  <= 8'h00;
      seq_error  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dir        <= dir_ok ? req : dir;
      dir_change <= dir_ok;
      pause      <= (space_make && !held) ? !pause : pause;
      held       <= space_make ? 1'b1 : space_rel ? 1'b0 : held;
      last_make  <= ((make && req_ok) || space_make) ? scancode : last_make;
      seq_error  <= err;
    end
  end
  always_comb begin
    state_nxt = state;
    err       = 1'b0;
    if (flag) begin
      case (state)
        IDLE:    state_nxt = is_e0 ? EXT : is_f0 ? BRK : IDLE;
        EXT:     begin state_nxt = is_f0 ? EXT_BRK : IDLE; err = is_e0; end
        default: begin state_nxt = IDLE; err = is_pfx; end
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
      err       = 1'b1;
    end
  end
  always_comb begin
    ext        = state == EXT;
    make       = flag && !is_pfx && (state == IDLE || ext);
    space_make = make && !ext && scancode == 8'h29;
    space_rel  = flag && state == BRK && scancode == 8'h29;
    req        = 2'b00;
    req_ok     = 1'b1;
    case ({ext, scancode})
      {1'b0, 8'h1D}, {1'b1, 8'h75}: req = 2'b00;
      {1'b0, 8'h1B}, {1'b1, 8'h72}: req = 2'b01;
      {1'b0, 8'h1C}, {1'b1, 8'h6B}: req = 2'b10;
      {1'b0, 8'h23}, {1'b1, 8'h74}: req = 2'b11;
      default:                      req_ok = 1'b0;
    endcase
    dir_ok = make && req_ok && !pause && req != dir && req != (dir ^ 2'b01);
  end
endmodule

// File: tb/tb_snake_key_decoder.sv
// tb_snake_key_decoder: directed plus random byte streams checked against a prefix-flag reference model.
module tb_snake_key_decoder;
  localparam int T = 50;
  logic CLK = 1'b0, RST_N = 1'b0, flag = 1'b0;
  logic [7:0] scancode = 8'h00;
  logic [1:0] dir;
  logic dir_change, pause, seq_error;
  logic [7:0] last_make;
  int checks = 0, fails = 0;
  bit pe, pb, held, m_pause, m_dc, m_se;
  int w;
  logic [1:0] m_dir;
  logic [7:0] m_lm;
  logic [7:0] nkeys [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
  logic [7:0] ekeys [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
  logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75,
                            8'h72, 8'h6B, 8'h74, 8'h29, 8'h29, 8'h12, 8'h5A};

  snake_key_decoder #(.PREFIX_TIMEOUT(T), .CNT_W(6)) dut (
    .CLK(CLK), .RST_N(RST_N), .scancode(scancode), .flag(flag), .dir(dir),
    .dir_change(dir_change), .pause(pause), .last_make(last_make), .seq_error(seq_error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pe = 0; pb = 0; held = 0; m_pause = 0; m_dc = 0; m_se = 0; w = 0;
    m_dir = 2'b11; m_lm = 8'h00;
  endtask

  task automatic model_make(input logic [7:0] b, input bit ext);
    int req = -1;
    for (int i = 0; i < 4; i++)
      if ((ext ? ekeys[i] : nkeys[i]) == b) req = i;
    if (req >= 0) begin
      m_lm = b;
      if (!m_pause && req != int'(m_dir) && req != int'(m_dir ^ 2'b01)) begin
        m_dir = 2'(req);
        m_dc = 1;
      end
    end else if (!ext && b == 8'h29) begin
      m_lm = b;
      if (!held) begin m_pause = !m_pause; held = 1; end
    end
  endtask

  task automatic model_step(input bit f, input logic [7:0] b);
    m_dc = 0; m_se = 0;
    if (f) begin
      w = 0;
      if (b == 8'hE0) begin
        if (!pe && !pb) pe = 1; else begin m_se = 1; pe = 0; pb = 0; end
      end else if (b == 8'hF0) begin
        if (!pb) pb = 1; else begin m_se = 1; pe = 0; pb = 0; end
      end else begin
        if (!pb) model_make(b, pe);
        else if (!pe && b == 8'h29) held = 0;
        pe = 0; pb = 0;
      end
    end else if (pe || pb) begin
      w++;
      if (w == T) begin m_se = 1; pe = 0; pb = 0; w = 0; end
    end
  endtask

  task automatic step(input bit f, input logic [7:0] b);
    flag = f; scancode = b;
    model_step(f, b);
    @(posedge CLK); #1;
    check("dir", dir, m_dir);
    check("dir_change", dir_change, m_dc);
    check("pause", pause, m_pause);
    check("last_make", last_make, m_lm);
    check("seq_error", seq_error, m_se);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1, b);
    repeat (gap) step(0, 8'h00);
  endtask

  task automatic do_reset();
    flag = 0;
    RST_N = 0;
    model_reset();
    #2;
    check("rst_dir", dir, 2'b11);
    check("rst_pause", pause, 0);
    check("rst_last_make", last_make, 8'h00);
    check("rst_seq_error", seq_error, 0);
    @(negedge CLK); RST_N = 1;
    @(posedge CLK); #1;
  endtask

  initial begin
    model_reset();
    @(posedge CLK); #1;
    do_reset();
    send(8'h75, 9);
    check("plain75_dir", dir, 2'b11);
    check("plain75_lm", last_make, 8'h00);
    send(8'hE0, 9);
    step(1, 8'h75);
    check("ext75_dir", dir, 2'b00);
    check("ext75_dc", dir_change, 1);
    check("ext75_lm", last_make, 8'h75);
    step(0, 8'h00);
    check("ext75_dc_drop", dir_change, 0);
    send(8'h1B, 3);
    check("opp_dir", dir, 2'b00);
    check("opp_lm", last_make, 8'h1B);
    send(8'h1C, 3);
    check("left_dir", dir, 2'b10);
    send(8'h29, 2); check("space1_pause", pause, 1);
    send(8'h29, 2); send(8'h29, 2); check("typematic_pause", pause, 1);
    send(8'hF0, 2); send(8'h29, 2); send(8'h29, 2);
    check("space2_pause", pause, 0);
    send(8'hF0, 2); send(8'h29, 2); send(8'h29, 2);
    send(8'h1D, 2);
    check("paused_dir", dir, 2'b10);
    send(8'hF0, 2); send(8'h29, 2); send(8'h29, 2);
    send(8'h1D, 2);
    check("up_dir", dir, 2'b00);
    step(1, 8'hE0);
    repeat (T - 1) step(0, 8'h00);
    step(0, 8'h00);
    check("timeout_se", seq_error, 1);
    step(0, 8'h00);
    check("timeout_se_drop", seq_error, 0);
    send(8'h23, 2);
    check("after_timeout_dir", dir, 2'b11);
    step(1, 8'hE0);
    repeat (T - 1) step(0, 8'h00);
    step(1, 8'h75);
    check("edge_byte_dir", dir, 2'b00);
    check("edge_byte_se", seq_error, 0);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h74, 1);
    check("ext_brk_dir", dir, 2'b00);
    send(8'hE0, 1); send(8'hE0, 0);
    check("ee_err", seq_error, 1);
    send(8'hE0, 3);
    do_reset();
    send(8'h75, 3);
    check("post_rst_dir", dir, 2'b11);
    check("post_rst_lm", last_make, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      int gap = ($urandom_range(0, 19) == 0) ? $urandom_range(T - 3, T + 3) : $urandom_range(0, 3);
      send(pool[$urandom_range(0, 13)], gap);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
